tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter N_CH, default 4, number of time-division slots (channels) per frame, range 2..16.
REQ-002 Parameter W, default 8, sample width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_vld  input  1  qualifies in_data/in_sof this cycle; no backpressure exists.
REQ-006 in_sof  input  1  start-of-frame; marks the slot-0 sample; ignored when in_vld=0.
REQ-007 in_data  input  W  serialized sample.
REQ-008 out_vld  output  1  one-cycle pulse when a complete frame is presented on out_data.
REQ-009 out_data  output  N_CH*W  channel k occupies bits [k*W +: W].
REQ-010 out_err  output  1  one-cycle pulse on any framing error.
REQ-011 out_err_cnt  output  8  saturating framing-error count (see Configuration).

Function
REQ-012 The block SHALL implement states HUNT, COLLECT and WAIT_SOF, plus a slot counter of $clog2(N_CH) bits.
REQ-013 HUNT: accepted beats without in_sof are discarded; in_vld&in_sof stores in_data to slot 0, sets slot=1, enters COLLECT.
REQ-014 COLLECT: accepted beat without in_sof stores to current slot and increments slot; the beat storing slot N_CH-1 enters WAIT_SOF.
REQ-015 out_vld SHALL rise in the cycle after the beat storing slot N_CH-1 (latency 1); out_data then holds all N_CH samples of that frame.
REQ-016 out_data SHALL only update on the cycle out_vld rises (shadow register); it holds its value between frames.
REQ-017 WAIT_SOF: in_vld&in_sof behaves as in HUNT (slot 0, enter COLLECT); in_vld without in_sof pulses out_err, discards the beat, enters HUNT.
REQ-018 COLLECT with in_vld&in_sof (short frame): out_err pulses next cycle, the partial frame is dropped (no out_vld), the beat is stored as slot 0, slot=1, state stays COLLECT.
REQ-019 in_vld=0 cycles SHALL not change state or slot in any state (gaps are legal).
REQ-020 N_CH=2..16 wrap: slot never exceeds N_CH-1; no out-of-range write occurs.
REQ-021 out_vld and out_err SHALL never be asserted in the same cycle.

Reset
REQ-022 rst SHALL asynchronously force state=HUNT, slot=0, out_vld=0, out_err=0, out_data=0, out_err_cnt=0.
REQ-023 rst asserted mid-frame SHALL discard the partial frame; no out_vld or out_err pulse follows reset deassertion.

Configuration
REQ-024 Macro TDM_DEMUX_ERR_CNT_EN defined: out_err_cnt increments on each out_err pulse, saturates at 255.
REQ-025 Macro TDM_DEMUX_ERR_CNT_EN undefined: counter logic absent, out_err_cnt tied to 0; all other behaviour identical.

Structure
REQ-026 Package tdm_demux_pkg SHALL hold the state enum typedef (HUNT, COLLECT, WAIT_SOF) and default constants for N_CH and W.
REQ-027 Sub-module demux_1toN SHALL decode slot into a one-hot N_CH-bit write enable gated by the accept condition; it is the inverse of the team's mux primitive.

Verification
REQ-028 N_CH=4,W=8: beats sof+0x11,0x22,0x33,0x44 back-to-back -> one cycle later out_vld=1, out_data=0x44332211, out_err=0.
REQ-029 Same frame with in_vld=0 gaps of 1..3 cycles between beats -> identical out_data, single out_vld pulse.
REQ-030 sof+0x11,0x22 then sof+0x55,0x66,0x77,0x88 -> out_err pulse after the second sof, then out_vld with out_data=0x88776655.
REQ-031 Full frame followed by a beat 0x99 without sof -> out_vld, then out_err; 0x99 ignored; subsequent non-sof beats ignored until next sof.
REQ-032 rst pulsed after two beats of a frame, then a clean frame -> all outputs 0 during reset, no pulse at deassertion, next frame decodes correctly.
REQ-033 With TDM_DEMUX_ERR_CNT_EN, 300 consecutive short frames -> out_err_cnt reaches 255 and holds; without macro out_err_cnt stays 0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM frame demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned N_CH_DEF = 4;
    localparam int unsigned W_DEF    = 8;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_SOF = 2'd2
    } state_t;

endpackage

// File: rtl/demux_1toN.sv
// Slot index to one-hot write-enable decoder, gated by the accept condition.
module demux_1toN
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF
) (
    input  logic                    en,
    input  logic [$clog2(N_CH)-1:0] sel,
    output logic [N_CH-1:0]         wen_c
);

    localparam int unsigned SW = $clog2(N_CH);

    // One enable per slot; all low when the beat is not accepted
    always_comb begin
        wen_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            wen_c[k] = en && (sel == SW'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM deserializer: gathers N_CH serialized samples into one parallel frame.
// Optional feature macro: TDM_DEMUX_ERR_CNT_EN enables the saturating
// framing-error counter on out_err_cnt (tied to zero otherwise).
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    input  logic                in_sof,
    input  logic [W-1:0]        in_data,
    output logic                out_vld,
    output logic [N_CH*W-1:0]   out_data,
    output logic                out_err,
    output logic [CNT_W-1:0]    out_err_cnt
);

    localparam int unsigned SW = $clog2(N_CH);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N_CH - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SW-1:0]          slot;
    logic [SW-1:0]          slot_nxt;

    logic                   wr_go_c;
    logic [SW-1:0]          wr_sel_c;
    logic                   done_c;
    logic                   err_c;
    logic [N_CH-1:0]        wen_c;
    logic [N_CH-1:0][W-1:0] slots_q;
    logic [N_CH-1:0][W-1:0] frame_c;

    // State and slot counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            slot  <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    // Next state; idle cycles leave state and slot untouched
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        if (in_vld) begin
            case (state)
                HUNT: begin
                    if (in_sof) begin
                        state_nxt = COLLECT;
                        slot_nxt  = SW'(1);
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        slot_nxt = SW'(1);
                    end else if (slot == SLOT_LAST) begin
                        state_nxt = WAIT_SOF;
                        slot_nxt  = '0;
                    end else begin
                        slot_nxt = slot + SW'(1);
                    end
                end
                WAIT_SOF: begin
                    if (in_sof) begin
                        state_nxt = COLLECT;
                        slot_nxt  = SW'(1);
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

    // Beat decode: write strobe, target slot, frame completion, framing error
    always_comb begin
        wr_go_c  = 1'b0;
        wr_sel_c = '0;
        done_c   = 1'b0;
        err_c    = 1'b0;
        if (in_vld) begin
            case (state)
                HUNT: begin
                    wr_go_c = in_sof;
                end
                COLLECT: begin
                    wr_go_c = 1'b1;
                    if (in_sof) begin
                        err_c = 1'b1;
                    end else begin
                        wr_sel_c = slot;
                        done_c   = (slot == SLOT_LAST);
                    end
                end
                WAIT_SOF: begin
                    if (in_sof) begin
                        wr_go_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    demux_1toN #(
        .N_CH (N_CH)
    ) u_wen (
        .en    (wr_go_c),
        .sel   (wr_sel_c),
        .wen_c (wen_c)
    );

    // Slot buffer with the current beat merged in, so a completing beat lands in the same edge
    always_comb begin
        frame_c = slots_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (wen_c[k]) begin
                frame_c[k] = in_data;
            end
        end
    end

    // Collection buffer, output shadow register and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q  <= '0;
            out_data <= '0;
            out_vld  <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            slots_q <= frame_c;
            out_vld <= done_c;
            out_err <= err_c;
            if (done_c) begin
                out_data <= frame_c;
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    // Saturating framing-error counter, steps together with the out_err pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err_cnt <= '0;
        end else if (err_c && (out_err_cnt != {CNT_W{1'b1}})) begin
            out_err_cnt <= out_err_cnt + CNT_W'(1);
        end
    end
`else
    assign out_err_cnt = '0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized + directed bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned DW   = N_CH * W;
    localparam int unsigned CW   = (DW > 8) ? DW : 8;
`ifdef TDM_DEMUX_ERR_CNT_EN
    localparam int EXP_SAT = 255;
`else
    localparam int EXP_SAT = 0;
`endif

    logic          clk;
    logic          rst;
    logic          in_vld;
    logic          in_sof;
    logic [W-1:0]  in_data;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic [7:0]    out_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: samples of the frame in progress, and whether
    // a complete frame was just seen so the next non-sof beat is an error.
    logic [W-1:0]  q[$];
    bit            armed;
    logic [DW-1:0] exp_data;
    int            exp_cnt;
    bit            ev;
    bit            ee;

    tdm_demux #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_err_cnt (out_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        armed    = 1'b0;
        exp_data = '0;
        exp_cnt  = 0;
    endtask

    // Apply one beat to the model: what out_vld/out_err must show next cycle
    task automatic model_beat(input logic v, input logic s, input logic [W-1:0] d);
        ev = 1'b0;
        ee = 1'b0;
        if (v) begin
            if (s) begin
                if (q.size() > 0) ee = 1'b1;
                q.delete();
                q.push_back(d);
                armed = 1'b0;
            end else if (q.size() > 0) begin
                q.push_back(d);
                if (q.size() == N_CH) begin
                    ev = 1'b1;
                    for (int k = 0; k < int'(N_CH); k++) exp_data[k*W +: W] = q[k];
                    q.delete();
                    armed = 1'b1;
                end
            end else if (armed) begin
                ee    = 1'b1;
                armed = 1'b0;
            end
        end
`ifdef TDM_DEMUX_ERR_CNT_EN
        if (ee && exp_cnt < 255) exp_cnt++;
`endif
    endtask

    // Drive one cycle, then check every output one edge later
    task automatic step(input logic v, input logic s, input logic [W-1:0] d);
        in_vld  = v;
        in_sof  = s;
        in_data = d;
        model_beat(v, s, d);
        @(posedge clk);
        #1;
        chk("out_vld", out_vld, ev);
        chk("out_err", out_err, ee);
        chk("out_data", out_data, exp_data);
        chk("out_err_cnt", out_err_cnt, exp_cnt);
        chk("vld_err_excl", out_vld & out_err, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        in_vld  = 1'b0;
        in_sof  = 1'b0;
        in_data = '0;
        rst     = 1'b1;
        #1;
        chk("rst_vld", out_vld, 0);
        chk("rst_err", out_err, 0);
        chk("rst_data", out_data, 0);
        chk("rst_cnt", out_err_cnt, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_vld", out_vld, 0);
        chk("rst_hold_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst_vld", out_vld, 0);
        chk("post_rst_err", out_err, 0);
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_sof  = 1'b0;
        in_data = '0;
        model_reset();
        apply_reset();

        // Back-to-back frame
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        chk("b2b_vld", out_vld, 1);
        chk("b2b_data", out_data, 32'h44332211);
        idle(2);

        // Same frame with idle gaps between beats
        step(1'b1, 1'b1, 8'h11);
        idle(1);
        step(1'b1, 1'b0, 8'h22);
        idle(2);
        step(1'b1, 1'b0, 8'h33);
        idle(3);
        step(1'b1, 1'b0, 8'h44);
        chk("gap_data", out_data, 32'h44332211);
        for (int i = 0; i < 3; i++) idle($urandom_range(1, 3));

        // Short frame then full frame
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h55);
        chk("short_err", out_err, 1);
        step(1'b1, 1'b0, 8'h66);
        step(1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b0, 8'h88);
        chk("short_next_vld", out_vld, 1);
        chk("short_next_data", out_data, 32'h88776655);
        idle(1);

        // Full frame, then stray non-sof beats
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        step(1'b1, 1'b0, 8'hA4);
        step(1'b1, 1'b0, 8'h99);
        chk("stray_err", out_err, 1);
        step(1'b1, 1'b0, 8'hBB);
        step(1'b1, 1'b0, 8'hCC);
        idle(1);
        chk("stray_hold", out_data, 32'hA4A3A2A1);

        // Reset mid-frame, then a clean frame
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        apply_reset();
        idle(2);
        step(1'b1, 1'b1, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 8'hC3);
        step(1'b1, 1'b0, 8'hC4);
        chk("post_rst_frame", out_data, 32'hC4C3C2C1);

        // Many consecutive short frames drive the error counter to saturation
        for (int i = 0; i < 310; i++) begin
            step(1'b1, 1'b1, W'(i));
            step(1'b1, 1'b0, W'(i + 1));
        end
        chk("cnt_sat", out_err_cnt, EXP_SAT);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
